// File: rtl/sd_read_photo_if.sv
// Bus between the photo sequencer, the SD sector-read controller and the frame-RAM write port.
// Optional rd_done strobe exists only when SD_READ_PHOTO_DONE_EN is defined.
interface sd_read_photo_if #(
    parameter int unsigned RAM_AW = 19
);
    // Strobe semantics (no back-pressure): rd_start_en is a one-cycle request that is only
    // raised while rd_busy=0; every cycle with rd_val_en=1 carries exactly one word, and
    // sd_rd_ram_addr in that same cycle is that word's frame-RAM address.
    logic              get_photo_mode;
    logic              rd_busy;
    logic              rd_val_en;
    logic              rd_start_en;
    logic [31:0]       rd_sec_addr;
    logic [RAM_AW-1:0] sd_rd_ram_addr;
`ifdef SD_READ_PHOTO_DONE_EN
    logic              rd_done;

    modport master (
        input  get_photo_mode, rd_busy, rd_val_en,
        output rd_start_en, rd_sec_addr, sd_rd_ram_addr, rd_done
    );
    modport slave (
        output get_photo_mode, rd_busy, rd_val_en,
        input  rd_start_en, rd_sec_addr, sd_rd_ram_addr, rd_done
    );
`else
    modport master (
        input  get_photo_mode, rd_busy, rd_val_en,
        output rd_start_en, rd_sec_addr, sd_rd_ram_addr
    );
    modport slave (
        output get_photo_mode, rd_busy, rd_val_en,
        input  rd_start_en, rd_sec_addr, sd_rd_ram_addr
    );
`endif
endinterface

// File: rtl/sd_read_photo.sv
// Streams SECTORS consecutive SD sectors from BASE_SEC into frame RAM, one address per word.
// Define SD_READ_PHOTO_DONE_EN to add the rd_done entry pulse on the bus.
module sd_read_photo #(
    parameter logic [31:0] BASE_SEC      = 32'd10000,
    parameter int unsigned SECTORS       = 1200,
    parameter int unsigned WORDS_PER_SEC = 256,
    parameter int unsigned RAM_AW        = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    sd_read_photo_if.master bus,
    output logic [2:0]      dbg_state_o
);
    localparam int unsigned SCW = (SECTORS > 1) ? $clog2(SECTORS) : 1;
    localparam int unsigned WCW = (WORDS_PER_SEC > 1) ? $clog2(WORDS_PER_SEC) : 1;
    localparam logic [SCW-1:0] SEC_LAST  = SCW'(SECTORS - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(WORDS_PER_SEC - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_XFER, S_WAIT, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [SCW-1:0]    sec_cnt_q, sec_cnt_d;
    logic [WCW-1:0]    word_cnt_q, word_cnt_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic              start_q, start_d;
    logic [31:0]       sec_addr_q, sec_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sec_cnt_q  <= '0;
            word_cnt_q <= '0;
            ram_addr_q <= '0;
            start_q    <= 1'b0;
            sec_addr_q <= BASE_SEC;
        end else begin
            state_q    <= state_d;
            sec_cnt_q  <= sec_cnt_d;
            word_cnt_q <= word_cnt_d;
            ram_addr_q <= ram_addr_d;
            start_q    <= start_d;
            sec_addr_q <= sec_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sec_cnt_d  = sec_cnt_q;
        word_cnt_d = word_cnt_q;
        ram_addr_d = ram_addr_q;
        sec_addr_d = sec_addr_q;
        case (state_q)
            S_IDLE: begin
                sec_cnt_d  = '0;
                word_cnt_d = '0;
                ram_addr_d = '0;
                if (bus.get_photo_mode && !bus.rd_busy) state_d = S_START;
            end
            S_START: state_d = S_XFER;
            S_XFER: begin
                if (bus.rd_val_en) begin
                    ram_addr_d = ram_addr_q + RAM_AW'(1);
                    if (word_cnt_q == WORD_LAST) begin
                        word_cnt_d = '0;
                        if (sec_cnt_q == SEC_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            sec_cnt_d = sec_cnt_q + SCW'(1);
                            state_d   = S_WAIT;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
            end
            S_WAIT: if (!bus.rd_busy) state_d = S_START;
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase
        // Dropping the request aborts any phase (or leaves DONE) with everything cleared.
        if (!bus.get_photo_mode) begin
            state_d    = S_IDLE;
            sec_cnt_d  = '0;
            word_cnt_d = '0;
            ram_addr_d = '0;
        end
        // Registered pulse lines up with the START state; address is held until the next one.
        start_d = (state_d == S_START);
        if (start_d) sec_addr_d = BASE_SEC + 32'(sec_cnt_d);
    end

    assign bus.rd_start_en    = start_q;
    assign bus.rd_sec_addr    = sec_addr_q;
    assign bus.sd_rd_ram_addr = ram_addr_q;
    assign dbg_state_o        = state_q;

`ifdef SD_READ_PHOTO_DONE_EN
    logic done_q, done_d;

    assign done_d = (state_d == S_DONE) && (state_q != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= done_d;
    end

    assign bus.rd_done = done_q;
`endif
endmodule

// File: tb/tb_sd_read_photo.sv
// Directed bench for sd_read_photo: a small-geometry instance plus a default-geometry instance.
// Expected sector and word addresses are queued when stimulus is driven and popped on DUT output.
module tb_sd_read_photo;
    localparam logic [31:0] BASE = 32'd100;
    localparam int unsigned SECS = 2;
    localparam int unsigned WPS  = 4;
    localparam int unsigned AW   = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_read_photo_if #(.RAM_AW(AW)) b1();
    sd_read_photo_if #(.RAM_AW(AW)) b2();
    logic [2:0] st1, st2;

    sd_read_photo #(.BASE_SEC(BASE), .SECTORS(SECS), .WORDS_PER_SEC(WPS), .RAM_AW(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.master), .dbg_state_o(st1)
    );
    sd_read_photo dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.master), .dbg_state_o(st2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sec_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

`ifdef SD_READ_PHOTO_DONE_EN
    int done_cnt = 0;
    logic [31:0] done_addr = '0;
    always @(negedge clk) begin
        if (b1.rd_done === 1'b1) begin
            done_cnt++;
            done_addr = 32'(b1.sd_rd_ram_addr);
        end
    end
`endif

    // Called at posedge+1; one word per call, back-to-back calls keep rd_val_en high.
    task automatic send_word1(input logic [31:0] a);
        exp_q.push_back(a);
        b1.rd_val_en = 1'b1;
        @(negedge clk);
        chk("word_addr", 32'(b1.sd_rd_ram_addr), exp_q.pop_front());
        @(posedge clk); #1;
        b1.rd_val_en = 1'b0;
    endtask

    task automatic wait_start1(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (b1.rd_start_en === 1'b1) seen = 1'b1;
        end
        chk({tag, "_start"}, 32'(b1.rd_start_en), 32'd1);
        if (seen && sec_q.size() > 0) chk({tag, "_sec"}, b1.rd_sec_addr, sec_q.pop_front());
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev, exp2;
        int starts;
        bit seen, v;

        b1.get_photo_mode = 1'b0; b1.rd_busy = 1'b0; b1.rd_val_en = 1'b0;
        b2.get_photo_mode = 1'b0; b2.rd_busy = 1'b0; b2.rd_val_en = 1'b0;

        // 1. reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", 32'(b1.rd_start_en), 32'd0);
        chk("rst_sec", b1.rd_sec_addr, BASE);
        chk("rst_addr", 32'(b1.sd_rd_ram_addr), 32'd0);
        chk("rst_state", 32'(st1), 32'd0);
        chk("rst_sec2", b2.rd_sec_addr, 32'd10000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2. full load with rd_val_en held high
        sec_q.push_back(BASE);
        sec_q.push_back(BASE + 32'd1);
        for (int i = 1; i <= SECS * WPS; i++) exp_q.push_back(32'(i));
        prev = '0;
        starts = 0;
        b1.get_photo_mode = 1'b1;
        b1.rd_val_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b1.rd_start_en === 1'b1) begin
                starts++;
                if (sec_q.size() > 0) chk("t2_sec", b1.rd_sec_addr, sec_q.pop_front());
                else chk("t2_extra_start", 32'(b1.rd_start_en), 32'd0);
            end
            if (32'(b1.sd_rd_ram_addr) != prev) begin
                if (exp_q.size() > 0) chk("t2_addr_step", 32'(b1.sd_rd_ram_addr), exp_q.pop_front());
                else chk("t2_addr_extra", 32'(b1.sd_rd_ram_addr), prev);
                prev = 32'(b1.sd_rd_ram_addr);
            end
        end
        chk("t2_starts", 32'(starts), 32'd2);
        chk("t2_done_addr", 32'(b1.sd_rd_ram_addr), 32'(SECS * WPS));
        chk("t2_words_left", 32'(exp_q.size()), 32'd0);
`ifdef SD_READ_PHOTO_DONE_EN
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);
        chk("t6_done_addr", done_addr, 32'(SECS * WPS));
`endif
        @(posedge clk); #1;
        b1.get_photo_mode = 1'b0;
        b1.rd_val_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_exit_addr", 32'(b1.sd_rd_ram_addr), 32'd0);
        @(posedge clk); #1;

        // 3. busy after sector 0 delays the second request; stray words in WAIT ignored
        sec_q.push_back(BASE);
        b1.get_photo_mode = 1'b1;
        wait_start1("t3a");
        for (int i = 0; i < WPS; i++) send_word1(32'(i));
        b1.rd_busy = 1'b1;
        b1.rd_val_en = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t3_busy_nostart", 32'(b1.rd_start_en), 32'd0);
            chk("t3_wait_addr", 32'(b1.sd_rd_ram_addr), 32'(WPS));
            @(posedge clk); #1;
        end
        b1.rd_busy = 1'b0;
        b1.rd_val_en = 1'b0;
        sec_q.push_back(BASE + 32'd1);
        wait_start1("t3b");
        for (int i = WPS; i < SECS * WPS; i++) send_word1(32'(i));
        repeat (3) begin
            @(negedge clk);
            chk("t3_done_hold", 32'(b1.sd_rd_ram_addr), 32'(SECS * WPS));
            chk("t3_no_third", 32'(b1.rd_start_en), 32'd0);
            @(posedge clk); #1;
        end
`ifdef SD_READ_PHOTO_DONE_EN
        chk("t6_done_cnt2", 32'(done_cnt), 32'd2);
`endif
        b1.get_photo_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 4. abort after 3 words, then restart from the first sector
        sec_q.push_back(BASE);
        b1.get_photo_mode = 1'b1;
        wait_start1("t4a");
        for (int i = 0; i < 3; i++) send_word1(32'(i));
        b1.get_photo_mode = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_abort_addr", 32'(b1.sd_rd_ram_addr), 32'd0);
        chk("t4_abort_state", 32'(st1), 32'd0);
        b1.rd_val_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_idle_nostart", 32'(b1.rd_start_en), 32'd0);
            chk("t4_idle_addr", 32'(b1.sd_rd_ram_addr), 32'd0);
        end
        @(posedge clk); #1;
        b1.rd_val_en = 1'b0;
        sec_q.push_back(BASE);
        b1.get_photo_mode = 1'b1;
        wait_start1("t4b");
        send_word1(32'd0);
        send_word1(32'd1);

        // async reset mid-transfer takes effect without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_addr", 32'(b1.sd_rd_ram_addr), 32'd0);
        chk("rst_mid_state", 32'(st1), 32'd0);
        chk("rst_mid_sec", b1.rd_sec_addr, BASE);
        b1.get_photo_mode = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 5. default geometry, rd_val_en toggling every 10 cycles
        b2.get_photo_mode = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (b2.rd_start_en === 1'b1) seen = 1'b1;
        end
        chk("t5_start", 32'(b2.rd_start_en), 32'd1);
        chk("t5_sec", b2.rd_sec_addr, 32'd10000);
        @(posedge clk); #1;
        exp2 = '0;
        for (int i = 0; i < 60; i++) begin
            v = ((i / 10) % 2) == 0;
            b2.rd_val_en = v;
            if (v) begin
                exp_q.push_back(exp2);
                exp2++;
            end
            @(negedge clk);
            if (v) chk("t5_word_addr", 32'(b2.sd_rd_ram_addr), exp_q.pop_front());
            else   chk("t5_hold_addr", 32'(b2.sd_rd_ram_addr), exp2);
            @(posedge clk); #1;
        end
        b2.rd_val_en = 1'b0;
        chk("t5_total", 32'(b2.sd_rd_ram_addr), 32'd30);
        b2.get_photo_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_exit_addr", 32'(b2.sd_rd_ram_addr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
